// File: rtl/extram_arbiter.sv
// Two-port arbiter and access sequencer for the external asynchronous SRAM.
// Define EXTRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: port 0 wins).
module extram_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2,
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [BE_W-1:0]   p0_be,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [BE_W-1:0]   p1_be,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_ADR,
    output logic [DATA_W-1:0] ram_Din,
    input  logic [DATA_W-1:0] ram_Dout,
    output logic              ram_CS,
    output logic              ram_OE,
    output logic              ram_WE,
    output logic [BE_W-1:0]   ram_BE
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t     state;
    state_t     state_d;
    logic [3:0] cnt;
    logic       we_q;
    logic       port_q;
    logic       any_req;
    logic       pick1;
    logic       last;

`ifdef EXTRAM_ARB_ROUND_ROBIN_EN
    logic last_grant;
`endif

    always_comb begin
        any_req = p0_req | p1_req;
`ifdef EXTRAM_ARB_ROUND_ROBIN_EN
        pick1 = p1_req & (~p0_req | ~last_grant);
`else
        pick1 = p1_req & ~p0_req;
`endif
        last    = (state == ACCESS) && (cnt == 4'd0);
        state_d = state;
        unique case (state)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (last) state_d = we_q ? RECOVER : IDLE;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            port_q    <= 1'b0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            ram_ADR   <= '0;
            ram_Din   <= '0;
            ram_CS    <= 1'b1;
            ram_OE    <= 1'b1;
            ram_WE    <= 1'b1;
            ram_BE    <= '1;
`ifdef EXTRAM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        we_q    <= pick1 ? p1_we : p0_we;
                        port_q  <= pick1;
                        ram_ADR <= pick1 ? p1_addr : p0_addr;
                        ram_Din <= pick1 ? p1_wdata : p0_wdata;
                        ram_BE  <= pick1 ? ~p1_be : ~p0_be;
                        ram_OE  <= pick1 ? p1_we : p0_we;
                        ram_WE  <= pick1 ? ~p1_we : ~p0_we;
                        ram_CS  <= 1'b0;
                        p0_gnt  <= ~pick1;
                        p1_gnt  <= pick1;
                        cnt     <= CNT_INIT;
`ifdef EXTRAM_ARB_ROUND_ROBIN_EN
                        last_grant <= pick1;
`endif
                    end
                end
                ACCESS: begin
                    if (last) begin
                        if (we_q) begin
                            // keep CS/ADR/BE/Din one more cycle for hold time
                            ram_WE <= 1'b1;
                        end else begin
                            ram_CS <= 1'b1;
                            ram_OE <= 1'b1;
                            ram_BE <= '1;
                            if (port_q) begin
                                p1_rvalid <= 1'b1;
                                p1_rdata  <= ram_Dout;
                            end else begin
                                p0_rvalid <= 1'b1;
                                p0_rdata  <= ram_Dout;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    ram_CS <= 1'b1;
                    ram_BE <= '1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_extram_arbiter.sv
// Scoreboard bench for extram_arbiter: directed accesses against a behavioural
// SRAM, with a monitor checking grants, read returns and pin-level cycles.
module tb_extram_arbiter;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [17:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic [1:0]  p0_be, p1_be;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [17:0] ram_ADR;
    logic [15:0] ram_Din, ram_Dout;
    logic        ram_CS, ram_OE, ram_WE;
    logic [1:0]  ram_BE;

    logic [15:0] mem [0:(1<<18)-1];

    typedef struct {
        logic        port;
        logic [15:0] data;
        logic        chk;
    } rv_t;
    typedef struct {
        logic [17:0] adr;
        logic [15:0] din;
        logic [1:0]  be;
    } wr_t;
    typedef struct {
        logic [17:0] adr;
        logic [1:0]  be;
    } rd_t;

    int  gnt_q[$];
    rv_t rv_q[$];
    wr_t wr_q[$];
    rd_t rd_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    extram_arbiter #(.ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset_(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_ADR(ram_ADR), .ram_Din(ram_Din), .ram_Dout(ram_Dout),
        .ram_CS(ram_CS), .ram_OE(ram_OE), .ram_WE(ram_WE), .ram_BE(ram_BE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural async SRAM with active-low byte lanes
    assign ram_Dout = (!ram_CS && !ram_OE) ? mem[ram_ADR] : 16'h0000;
    always @(posedge clk) begin
        if (!ram_CS && !ram_WE) begin
            if (!ram_BE[0]) mem[ram_ADR][7:0]  <= ram_Din[7:0];
            if (!ram_BE[1]) mem[ram_ADR][15:8] <= ram_Din[15:8];
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor state
    int          gnt_cyc[2];
    int          we_len = 0;
    int          oe_len = 0;
    logic [17:0] w_adr, r_adr;
    logic [15:0] w_din;
    logic [1:0]  w_be, r_be;

    always @(negedge clk) begin
        logic [1:0] g, v;
        logic [15:0] rd;
        check("pin_exclusive",
              64'((!ram_OE && !ram_WE) || (!ram_WE && ram_CS)), 64'd0);
        g = {p1_gnt, p0_gnt};
        v = {p1_rvalid, p0_rvalid};
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                gnt_cyc[p] = cyc;
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 64'(p), 64'hFF);
                end else begin
                    check("gnt_port", 64'(p), 64'(gnt_q.pop_front()));
                end
            end
            if (v[p]) begin
                rd = p ? p1_rdata : p0_rdata;
                if (rv_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(p), 64'hFF);
                end else begin
                    rv_t e;
                    e = rv_q.pop_front();
                    check("rvalid_port", 64'(p), 64'(e.port));
                    check("rvalid_latency", 64'(cyc - gnt_cyc[p]), 64'(AC));
                    if (e.chk) check("rdata", 64'(rd), 64'(e.data));
                end
            end
        end
        if (!rst_n) begin
            we_len = 0;
            oe_len = 0;
        end else begin
            if (!ram_WE) begin
                we_len++;
                w_adr = ram_ADR;
                w_din = ram_Din;
                w_be  = ram_BE;
            end else if (we_len != 0) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'(w_adr), 64'h3FFFFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("we_len", 64'(we_len), 64'(AC));
                    check("wr_adr", 64'(w_adr), 64'(e.adr));
                    check("wr_din", 64'(w_din), 64'(e.din));
                    check("wr_be", 64'(w_be), 64'(e.be));
                    check("recover_hold",
                          64'({ram_CS, ram_ADR == w_adr, ram_Din == w_din, ram_BE == w_be}),
                          64'b0111);
                end
                we_len = 0;
            end
            if (!ram_OE) begin
                oe_len++;
                r_adr = ram_ADR;
                r_be  = ram_BE;
            end else if (oe_len != 0) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 64'(r_adr), 64'h3FFFFFF);
                end else begin
                    rd_t e;
                    e = rd_q.pop_front();
                    check("oe_len", 64'(oe_len), 64'(AC));
                    check("rd_adr", 64'(r_adr), 64'(e.adr));
                    check("rd_be", 64'(r_be), 64'(e.be));
                end
                oe_len = 0;
            end
        end
    end

    task automatic idle_inputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
    endtask

    task automatic drive(input int p, input logic we, input logic [17:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        if (p == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
        end
    endtask

    task automatic wait_gnt();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(p0_gnt || p1_gnt) && n < 20);
        if (!(p0_gnt || p1_gnt)) check("gnt_timeout", 64'd0, 64'd1);
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic settle();
        repeat (AC + 2) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int p, input logic we, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        input logic [15:0] exp, input logic chk);
        gnt_q.push_back(p);
        if (we) begin
            wr_q.push_back('{a, d, ~be});
        end else begin
            rd_q.push_back('{a, ~be});
            rv_q.push_back('{p[0], exp, chk});
        end
        drive(p, we, a, d, be);
        wait_gnt();
        settle();
    endtask

    task automatic contend(input int w, input logic [17:0] a,
                           input logic [15:0] exp);
        gnt_q.push_back(w);
        rd_q.push_back('{a, 2'b00});
        rv_q.push_back('{w[0], exp, 1'b1});
        drive(0, 1'b0, a, 16'h0, 2'b11);
        drive(1, 1'b0, a, 16'h0, 2'b11);
        wait_gnt();
        settle();
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("reset_pins", 64'({ram_CS, ram_OE, ram_WE, ram_BE}), 64'b11111);
        check("reset_adr_din", 64'({ram_ADR, ram_Din}), 64'd0);
        check("reset_rdata", 64'({p0_rdata, p1_rdata}), 64'd0);

        // port 0 first so port 1 owns last_grant before contention
        xfer(0, 1'b1, 18'h2A5A5, 16'h0000, 2'b11, 16'h0, 1'b0);
        xfer(0, 1'b1, 18'h2A5A5, 16'hA55A, 2'b10, 16'h0, 1'b0);
        xfer(0, 1'b0, 18'h2A5A5, 16'h0000, 2'b11, 16'hA500, 1'b1);
        xfer(0, 1'b0, 18'h2A5A5, 16'h0000, 2'b00, 16'h0, 1'b0);

        xfer(1, 1'b1, 18'h00123, 16'hBEEF, 2'b11, 16'h0, 1'b0);
        xfer(1, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hBEEF, 1'b1);
        xfer(1, 1'b1, 18'h00123, 16'h1234, 2'b01, 16'h0, 1'b0);
        xfer(1, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hBE34, 1'b1);

        for (int i = 0; i < 4; i++) begin
`ifdef EXTRAM_ARB_ROUND_ROBIN_EN
            contend(i % 2, 18'h00123, 16'hBE34);
`else
            contend(0, 18'h00123, 16'hBE34);
`endif
        end

        // abort a write in its second ACCESS cycle
        gnt_q.push_back(1);
        drive(1, 1'b1, 18'h3FFFF, 16'h5555, 2'b11);
        wait_gnt();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_pins", 64'({ram_CS, ram_OE, ram_WE, ram_BE}), 64'b11111);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_idle_pins", 64'({ram_CS, ram_OE, ram_WE}), 64'b111);

        xfer(0, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hBE34, 1'b1);
        contend(0, 18'h00123, 16'hBE34);

        repeat (5) @(posedge clk);
        #1;
        check("queues_drained",
              64'(gnt_q.size() + rv_q.size() + wr_q.size() + rd_q.size()),
              64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
